// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - tick-driven player/enemy overlap scan, hit/lives bookkeeping and game FSM
module collision_scheduler #(
  parameter int N_ENEMY      = 4,
  parameter int HIT_RADIUS   = 10,
  parameter int LIVES_INIT   = 3,
  parameter int FREEZE_TICKS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_tick,
  input  logic                   start,
  input  logic [9:0]             player_x,
  input  logic [9:0]             player_y,
  input  logic [10*N_ENEMY-1:0]  enemy_x,
  input  logic [10*N_ENEMY-1:0]  enemy_y,
  output logic [2:0]             state,
  output logic                   freeze,
  output logic                   collision_flag,
  output logic                   hit_pulse,
  output logic [7:0]             hit_count,
  output logic [1:0]             lives
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_SCAN   = 3'd2,
    S_EVAL   = 3'd3,
    S_FREEZE = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam int IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam logic [10:0] RADIUS = 11'(HIT_RADIUS);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx;
  logic [9:0]             snap_px, snap_py;
  logic [10*N_ENEMY-1:0]  snap_ex, snap_ey;
  logic [N_ENEMY-1:0]     cur_vec, prev_vec, new_vec;
  logic [7:0]             frz_cnt;
  logic [9:0]             sel_ex, sel_ey;
  logic signed [10:0]     dx, dy;
  logic [10:0]            adx, ady;
  logic                   hit, last_idx;

  // One shared comparator; the scan index picks which snapshotted enemy it sees.
  always_comb begin
    sel_ex   = snap_ex[32'(idx)*10 +: 10];
    sel_ey   = snap_ey[32'(idx)*10 +: 10];
    dx       = $signed({1'b0, snap_px}) - $signed({1'b0, sel_ex});
    dy       = $signed({1'b0, snap_py}) - $signed({1'b0, sel_ey});
    adx      = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady      = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    hit      = (adx <= RADIUS) && (ady <= RADIUS);
    last_idx = (idx == IW'(N_ENEMY - 1));
    new_vec  = cur_vec & ~prev_vec;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PLAY;
      S_PLAY:   if (move_tick) state_d = S_SCAN;
      S_SCAN:   if (last_idx) state_d = S_EVAL;
      S_EVAL: begin
        if (|new_vec) state_d = (lives == 2'd1) ? S_OVER : S_FREEZE;
        else          state_d = S_PLAY;
      end
      S_FREEZE: if (move_tick && frz_cnt <= 8'd1) state_d = S_PLAY;
      S_OVER:   if (start) state_d = S_PLAY;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      freeze  <= 1'b1;
    end else begin
      state_q <= state_d;
      freeze  <= (state_d == S_IDLE) || (state_d == S_FREEZE) || (state_d == S_OVER);
    end
  end

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      snap_px        <= '0;
      snap_py        <= '0;
      snap_ex        <= '0;
      snap_ey        <= '0;
      cur_vec        <= '0;
      prev_vec       <= '0;
      frz_cnt        <= '0;
      collision_flag <= 1'b0;
      hit_pulse      <= 1'b0;
      hit_count      <= '0;
      lives          <= 2'(LIVES_INIT);
    end else begin
      hit_pulse <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            lives     <= 2'(LIVES_INIT);
            hit_count <= '0;
            prev_vec  <= '0;
          end
        end
        S_PLAY: begin
          if (move_tick) begin
            snap_px <= player_x;
            snap_py <= player_y;
            snap_ex <= enemy_x;
            snap_ey <= enemy_y;
            cur_vec <= '0;
            idx     <= '0;
          end
        end
        S_SCAN: begin
          cur_vec[idx] <= hit;
          idx          <= idx + 1'b1;
        end
        S_EVAL: begin
          prev_vec       <= cur_vec;
          collision_flag <= |cur_vec;
          // A scan scores at most one hit however many enemies are newly touching.
          if (|new_vec) begin
            hit_pulse <= 1'b1;
            hit_count <= hit_count + 8'd1;
            if (lives == 2'd1) begin
              lives <= 2'd0;
            end else begin
              lives   <= lives - 2'd1;
              frz_cnt <= 8'(FREEZE_TICKS);
            end
          end
        end
        S_FREEZE: if (move_tick) frz_cnt <= frz_cnt - 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Game-level collision controller between the object block controllers and the VGA/SSD outputs. Once per movement tick it snapshots the player and enemy positions and time-multiplexes a single overlap comparator across all enemies, one enemy per clock. It edge-detects new overlaps, maintains the hit count and lives, and runs the game state machine. Its `freeze` output halts object movement during hit recovery and game over.

## Interface
- `N_ENEMY`, default 4: number of enemy blocks scanned; range 1–8.
- `HIT_RADIUS`, default 10: overlap threshold in pixels, applied per axis and inclusive.
- `LIVES_INIT`, default 3: lives loaded at reset and at game start; range 1–3.
- `FREEZE_TICKS`, default 32: movement ticks spent frozen after a hit; range 1–255.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: reset, asynchronous, active-high.
- `move_tick` in 1: single-cycle pulse at the movement rate.
- `start` in 1: single-cycle start pulse, already debounced.
- `player_x`, `player_y` in 10 each: player block position in pixels.
- `enemy_x`, `enemy_y` in 10*N_ENEMY each: packed enemy positions; enemy i occupies bits [10i+9:10i].
- `state` out 3: game state code. IDLE=0, PLAY=1, SCAN=2, EVAL=3, FREEZE=4, OVER=5.
- `freeze` out 1: high in IDLE, FREEZE and OVER.
- `collision_flag` out 1: high when at least one enemy overlapped the player in the last completed scan.
- `hit_pulse` out 1: one-cycle pulse when a scan finds at least one new hit.
- `hit_count` out 8: number of scans that produced a new hit; wraps from 255 to 0.
- `lives` out 2: remaining lives.

## Operation
- Reset values:
  - `state`=IDLE, `freeze`=1, `collision_flag`=0, `hit_pulse`=0, `hit_count`=0, `lives`=LIVES_INIT.
  - Internal `prev_vec` (N_ENEMY bits) and `cur_vec` cleared.
  - Scan index = 0, freeze counter = 0.
- Overlap test for enemy i:
  - dx = {1'b0,player_x} − {1'b0,enemy_x[i]} as an 11-bit signed value; dy is formed the same way.
  - hit_i = (|dx| ≤ HIT_RADIUS) && (|dy| ≤ HIT_RADIUS).
  - There is no modular wrap: player_x=1000 and enemy_x=5 is not a hit.
- State transitions:
  - IDLE: `start` → PLAY. Entering PLAY loads `lives`=LIVES_INIT, `hit_count`=0, `prev_vec`=0. `move_tick` is ignored.
  - PLAY: `move_tick` → SCAN. The same cycle latches all positions into snapshot registers, clears `cur_vec` and sets index=0.
  - SCAN: each cycle, evaluate snapshot enemy[index] and write the result into `cur_vec[index]`, then increment index. After enemy N_ENEMY−1 is evaluated, go to EVAL. Any `move_tick` during SCAN or EVAL is dropped.
  - EVAL (1 cycle):
    - new = `cur_vec` & ~`prev_vec`; `prev_vec` ← `cur_vec`; `collision_flag` ← |`cur_vec`.
    - If new≠0: `hit_pulse`=1 for this cycle and `hit_count`+1 (once per scan regardless of popcount(new)).
    - If new≠0 and `lives`==1: `lives`←0, go to OVER.
    - Else if new≠0: `lives`−1, load freeze counter with FREEZE_TICKS, go to FREEZE.
    - Else go to PLAY.
  - FREEZE: each `move_tick` decrements the counter. The tick that brings it to 0 returns to PLAY. No scans run; `prev_vec` and `collision_flag` hold their values.
  - OVER: `start` → PLAY with the same reload as from IDLE. Everything else holds.
- `start` is ignored in PLAY, SCAN, EVAL and FREEZE.
- An enemy that still overlaps after a freeze is not a new hit. It must leave the hit box and re-enter to score again.
- Reset asserted mid-scan aborts the scan immediately; all registers return to reset values.

## Timing
- All outputs are registered.
- `state`/`freeze` change in the cycle after the causing event.
- `move_tick` sampled high in PLAY at cycle T:
  - The snapshot is taken at the T edge.
  - Enemy i is evaluated in cycle T+1+i.
  - EVAL occurs in cycle T+1+N_ENEMY.
  - `hit_pulse`, `collision_flag`, `hit_count` and `lives` update on the edge ending EVAL and are visible in cycle T+2+N_ENEMY.
  - PLAY, FREEZE or OVER is entered in that same cycle.
- Scan latency is N_ENEMY+2 cycles. It is always far shorter than the tick period (2^19 cycles), so ticks are never lost in normal use.
- Position changes after the snapshot do not affect the scan in progress.

## Test plan
- Reset, then `start`: `state`=1, `lives`=3, `freeze`=0, `hit_count`=0. Ten ticks with all enemies far away → `collision_flag`=0, no `hit_pulse`.
- Boundary: player (100,100), enemy 2 at (110,90), tick → exactly one `hit_pulse` at T+6, `hit_count`=1, `lives`=2, `state`=4. Enemy at (111,100) → no hit.
- No wrap: player (1000,5), enemy (5,5) → no hit. Player (3,3), enemy (0,0) → hit.
- Persistence: the overlap is held through 32 freeze ticks and 5 further play ticks → `state` returns to 1 after the 32nd tick, no further `hit_pulse`, `collision_flag`=1. Move the enemy away and back → second hit, `hit_count`=2.
- Two enemies newly overlapping in the same scan → `hit_count` +1 and `lives` −1 only. The third life lost → `state`=5, `lives`=0, `freeze`=1. `start` → `state`=1, `lives`=3, `hit_count`=0.
- Assert `rst` during cycle T+3 of a scan → all outputs at reset values next cycle. Extra `move_tick` pulses during SCAN are ignored (exactly one EVAL per accepted tick).
